// File: rtl/axis_burst_reader.sv
//==============================================================================
// Module   : axis_burst_reader
// Purpose  : Drains a sample FIFO in fixed BURST_LEN bursts and emits them as
//            framed AXI-Stream packets (tlast on the final beat), with an
//            optional idle gap after each burst.
// Options  : define AXIS_BURST_READER_TLAST_CHECK_EN to enable the sticky
//            input-tlast framing check on tlast_err_o.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module axis_burst_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int USER_WIDTH  = 1,
  parameter int LEVEL_WIDTH = 3,
  parameter int BURST_LEN   = 4,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [DATA_WIDTH-1:0]  s_axis_in_tdata,
  input  logic [USER_WIDTH-1:0]  s_axis_in_tuser,
  input  logic                   s_axis_in_tlast,
  input  logic                   s_axis_in_tvalid,
  output logic                   s_axis_in_tready,
  input  logic [LEVEL_WIDTH-1:0] s_axis_in_tlevel,
  output logic [DATA_WIDTH-1:0]  m_axis_out_tdata,
  output logic [USER_WIDTH-1:0]  m_axis_out_tuser,
  output logic                   m_axis_out_tlast,
  output logic                   m_axis_out_tvalid,
  input  logic                   m_axis_out_tready,
  output logic [15:0]            burst_cnt_o,
  output logic                   tlast_err_o
);

  localparam int c_beat_w = $clog2(BURST_LEN + 1);
  localparam int c_gap_w  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [c_beat_w-1:0]    c_last_beat   = c_beat_w'(BURST_LEN - 1);
  localparam logic [c_gap_w-1:0]     c_gap_last    = (GAP_CYCLES > 0) ? c_gap_w'(GAP_CYCLES - 1) : '0;
  localparam logic [LEVEL_WIDTH-1:0] c_burst_level = LEVEL_WIDTH'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_beat_w-1:0]   r_beat_cnt;
  logic [c_gap_w-1:0]    r_gap_cnt;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [USER_WIDTH-1:0] r_tuser;
  logic                  r_tlast;
  logic                  r_tvalid;
  logic [15:0]           r_burst_cnt;

  logic w_in_ready;
  logic w_accept;
  logic w_last_beat;

  // Pop only while the output register is empty or being drained this cycle.
  assign w_in_ready  = (r_state == S_BURST) && (!r_tvalid || m_axis_out_tready);
  assign w_accept    = s_axis_in_tvalid && w_in_ready;
  assign w_last_beat = (r_beat_cnt == c_last_beat);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state     <= S_IDLE;
      r_beat_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_tdata     <= '0;
      r_tuser     <= '0;
      r_tlast     <= 1'b0;
      r_tvalid    <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_tdata  <= s_axis_in_tdata;
        r_tuser  <= s_axis_in_tuser;
        r_tlast  <= w_last_beat;
        r_tvalid <= 1'b1;
      end else if (m_axis_out_tready) begin
        r_tvalid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_beat_cnt <= '0;
          if (s_axis_in_tlevel >= c_burst_level) begin
            r_state <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + c_beat_w'(1);
            if (w_last_beat) begin
              r_burst_cnt <= r_burst_cnt + 16'd1;
              r_gap_cnt   <= '0;
              r_state     <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == c_gap_last) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + c_gap_w'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_axis_in_tready  = w_in_ready;
  assign m_axis_out_tdata  = r_tdata;
  assign m_axis_out_tuser  = r_tuser;
  assign m_axis_out_tlast  = r_tlast;
  assign m_axis_out_tvalid = r_tvalid;
  assign burst_cnt_o       = r_burst_cnt;

`ifdef AXIS_BURST_READER_TLAST_CHECK_EN
  logic r_tlast_err;

  // Sticky: any accepted beat whose FIFO tlast disagrees with our framing.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_tlast_err <= 1'b0;
    end else if (w_accept && (s_axis_in_tlast != w_last_beat)) begin
      r_tlast_err <= 1'b1;
    end
  end

  assign tlast_err_o = r_tlast_err;
`else
  logic w_unused_tlast;

  assign w_unused_tlast = s_axis_in_tlast;
  assign tlast_err_o    = 1'b0;
`endif

endmodule

`default_nettype wire
